// File: rtl/peripheral_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// peripheral_uart_rx
//   J1 I/O-bus slave that receives 8N1 serial data and buffers the received
//   bytes in a small FIFO. Firmware polls STATUS and pops bytes through DATA.
//
//   Register map (accesses qualified by cs):
//     4'h0 DATA   read : {8'h00, FIFO head} (16'h0000 when empty); pops
//     4'h2 STATUS read : {12'h000, overrun, frame_err, full, ~empty}
//     4'h2 STATUS write: d_in[3]=1 clears overrun, d_in[2]=1 clears frame_err
//     others           : read 16'h0000, writes ignored
//
//   Ports:
//     clk      system clock, rising edge
//     rst      asynchronous active-high reset
//     d_in     bus write data
//     cs       chip-select from the SoC address decoder
//     addr     register offset
//     rd, wr   one-cycle bus strobes
//     d_out    combinational read data (16'h0000 when cs=0)
//     uart_rx  serial line, idle high, asynchronous to clk
//     rx_avail high while the FIFO holds at least one byte
//
//   FIFO_DEPTH must be a power of 2 and at least 2.
// -----------------------------------------------------------------------------
module peripheral_uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_avail
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronizer plus one delayed copy for falling-edge detection.
    // Preset to 1 so reset release never looks like a start edge.
    // ---------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    logic rx_fall;
    assign rx_fall = rx_prev & ~rx_sync;

    // ---------------------------------------------------------------------
    // 16x oversampling tick; free-running, cleared only by reset.
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] tc_q, tc_d;
    logic [2:0] bi_q, bi_d;
    logic [7:0] shreg_q, shreg_d;
    logic       push_req;
    logic       frame_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tc_q    <= '0;
            bi_q    <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            bi_q    <= bi_d;
            shreg_q <= shreg_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tc_d      = tc_q;
        bi_d      = bi_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        frame_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    tc_d    = '0;
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (tc_q == 4'd7) begin
                        // Mid start bit: a high line means the edge was a glitch.
                        if (!rx_sync) begin
                            tc_d    = '0;
                            bi_d    = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    // tc wraps 15 -> 0 on its own; the wrap marks mid-bit.
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        shreg_d = {rx_sync, shreg_q[7:1]};
                        bi_d    = bi_q + 3'd1;
                        if (bi_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        if (rx_sync) begin
                            push_req = 1'b1;
                        end else begin
                            frame_set = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Receive FIFO; pointers carry one extra wrap bit to tell full from empty.
    // ---------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic        empty, full, pop, push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = cs & rd & (addr == 4'h0) & ~empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push  = push_req & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= shreg_q;
    end

    // ---------------------------------------------------------------------
    // Sticky error flags; a set event beats a same-cycle clear.
    // ---------------------------------------------------------------------
    logic overrun, frame_err, status_wr;

    assign status_wr = cs & wr & (addr == 4'h2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_req && !push)          overrun <= 1'b1;
            else if (status_wr && d_in[3])  overrun <= 1'b0;

            if (frame_set)                  frame_err <= 1'b1;
            else if (status_wr && d_in[2])  frame_err <= 1'b0;
        end
    end

    logic unused_d_in;
    assign unused_d_in = ^{d_in[15:4], d_in[1:0]};

    // ---------------------------------------------------------------------
    // Bus read mux and status output
    // ---------------------------------------------------------------------
    always_comb begin
        d_out = 16'h0000;
        if (cs) begin
            case (addr)
                4'h0: if (!empty) d_out = {8'h00, mem[rptr[AW-1:0]]};
                4'h2: d_out = {12'h000, overrun, frame_err, full, ~empty};
                default: d_out = 16'h0000;
            endcase
        end
    end

    assign rx_avail = ~empty;

endmodule

// File: tb/tb_peripheral_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for peripheral_uart_rx: directed scenarios plus random
// frames, compared against a frame-level queue model of the receiver.
module tb_peripheral_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        uart_rx;
    logic        rx_avail;

    int checks = 0;
    int errors = 0;

    // Reference model: received bytes in arrival order plus the two flags.
    logic [7:0] model_q[$];
    logic       model_ovr;
    logic       model_ferr;

    peripheral_uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .cs      (cs),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out),
        .uart_rx (uart_rx),
        .rx_avail(rx_avail)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [15:0] exp_status();
        return {12'h000, model_ovr, model_ferr,
                model_q.size() == DEPTH, model_q.size() != 0};
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (!stop)                    model_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else                          model_ovr = 1'b1;
    endfunction

    function automatic logic [15:0] model_pop();
        logic [7:0] b;
        if (model_q.size() == 0) return 16'h0000;
        b = model_q.pop_front();
        return {8'h00, b};
    endfunction

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] data);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 data = d_out;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 4'h0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
    endtask

    task automatic read_data_check(input string tag);
        logic [15:0] d;
        logic [15:0] e;
        e = model_pop();
        bus_read(4'h0, d);
        check(tag, d, e);
    endtask

    task automatic status_check(input string tag);
        logic [15:0] d;
        check({tag, "_avail"}, {15'h0, rx_avail}, {15'h0, model_q.size() != 0});
        bus_read(4'h2, d);
        check(tag, d, exp_status());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] d_bnd;
        logic [15:0] rdv;
        logic [7:0]  rb;
        logic        rs;
        logic [7:0]  abort_byte;

        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 4'h0; d_in = 16'h0000; uart_rx = 1'b1;
        model_q.delete(); model_ovr = 1'b0; model_ferr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        cs = 1'b1; addr = 4'h2;
        #1 check("rst_status", d_out, 16'h0000);
        check("rst_avail", {15'h0, rx_avail}, 16'h0000);
        cs = 1'b0; addr = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte
        send_frame(8'h55, 1'b1); model_frame(8'h55, 1'b1);
        status_check("single_status");
        read_data_check("single_data");
        status_check("single_after");

        // Unmapped offset reads zero
        bus_read(4'h5, rdv);
        check("unmapped_rd", rdv, 16'h0000);

        // Glitch: 4 clk low, then high
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        status_check("glitch_status");

        // Frame error
        send_frame(8'hA3, 1'b0); model_frame(8'hA3, 1'b0);
        repeat (4) @(negedge clk);
        status_check("ferr_status");
        bus_write(4'h2, 16'h0004); model_ferr = 1'b0;
        status_check("ferr_clear");

        // Overrun: five bytes, no reads
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        status_check("ovr_status");
        for (int i = 0; i < 5; i++) read_data_check("ovr_data");
        status_check("ovr_drained");
        bus_write(4'h2, 16'h0008); model_ovr = 1'b0;
        status_check("ovr_clear");

        // Full boundary: pop on the same edge the fifth byte is pushed.
        // The push edge is the 155th rising edge after the start bit is driven.
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(8'h10 + i), 1'b1);
            model_frame(8'(8'h10 + i), 1'b1);
        end
        status_check("bnd_full");
        d_bnd = 16'hxxxx;
        fork
            send_frame(8'h15, 1'b1);
            begin
                repeat (154) @(negedge clk);
                bus_read(4'h0, d_bnd);
            end
        join
        check("bnd_pop", d_bnd, model_pop());
        model_frame(8'h15, 1'b1);
        status_check("bnd_status");
        for (int i = 0; i < 5; i++) read_data_check("bnd_data");

        // Random frames with random reads and flag clears
        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs); model_frame(rb, rs);
            status_check("rnd_status");
            if ($urandom_range(0, 1) == 1) read_data_check("rnd_data");
            if ($urandom_range(0, 2) == 0) begin
                rdv = {12'h000, 2'($urandom), 2'b00};
                bus_write(4'h2, rdv);
                if (rdv[3]) model_ovr = 1'b0;
                if (rdv[2]) model_ferr = 1'b0;
                status_check("rnd_clear");
            end
        end
        while (model_q.size() != 0) read_data_check("rnd_drain");
        bus_write(4'h2, 16'h000C); model_ovr = 1'b0; model_ferr = 1'b0;
        status_check("rnd_end");

        // Reset mid-frame, during data bit 4, with one byte already buffered
        send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1);
        abort_byte = 8'hC3;
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = abort_byte[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = abort_byte[4];
        repeat (8) @(negedge clk);
        check("pre_rst_avail", {15'h0, rx_avail}, 16'h0001);
        cs = 1'b1; addr = 4'h0;
        #1 rst = 1'b1;
        #1 check("rst_async_dout", d_out, 16'h0000);
        check("rst_async_avail", {15'h0, rx_avail}, 16'h0000);
        cs = 1'b0;
        uart_rx = 1'b1;
        model_q.delete(); model_ovr = 1'b0; model_ferr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        status_check("post_rst_status");
        send_frame(8'h7E, 1'b1); model_frame(8'h7E, 1'b1);
        status_check("post_rst_rx");
        read_data_check("post_rst_data");
        status_check("post_rst_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peripheral_uart_rx.md
Name: peripheral_uart_rx

Overview:
- J1 I/O-bus slave that receives 8N1 serial data on `uart_rx` and buffers the bytes in a 4-entry FIFO.
- Serves as the receive counterpart of the transmit-only UART peripheral.
- Decoded in `j1soc` at `j1_io_addr[15:8] = 8'h6A` through its own chip-select.
- Firmware polls the status register and pops bytes through the data register.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- d_in  input  16  J1 write data (`j1_io_dout`).
- cs  input  1  chip-select from the SoC address decoder.
- addr  input  4  register offset (`j1_io_addr[3:0]`).
- rd  input  1  J1 read strobe; one cycle per access.
- wr  input  1  J1 write strobe; one cycle per access.
- d_out  output  16  read data to the SoC read mux.
- uart_rx  input  1  serial line; idle high; asynchronous to clk.
- rx_avail  output  1  high while the FIFO is non-empty (LED/interrupt use).

Behaviour:
- Reset: asynchronous and active-high; all state clears immediately, independent of clk.
  - FSM goes to IDLE; FIFO is emptied; error flags clear.
  - Synchronizer flops preset to 1.
  - d_out = 16'h0000; rx_avail = 0.
  - Reset asserted mid-frame aborts the frame; no partial byte is stored.
- Input conditioning: `uart_rx` passes through 2 flops. Start detection uses the synchronized value and its 1-cycle delayed copy.
- Oversampling tick:
  - DIV = CLK_FREQ/(BAUD*16), integer-truncated, minimum 1.
  - A counter 0..DIV-1 produces a one-clk tick at wrap.
  - The counter free-runs and is reset only by rst.
- FSM, with a 4-bit tick counter (tc) and a 3-bit bit index (bi):
  - IDLE: on a synced falling edge (prev=1, now=0), clear tc, go to START.
  - START: count ticks. At tc=7 (mid start bit), sample the line:
    - line=0: clear tc and bi, go to DATA.
    - line=1: treat as a glitch, go to IDLE; nothing is stored.
  - DATA: every 16 ticks (tc wraps 15→0), sample and shift into the shift register, LSB first.
    - After bi=7 is sampled, go to STOP.
  - STOP: after 16 ticks, sample the line:
    - line=1: push the byte into the FIFO.
    - line=0: set frame_err and discard the byte.
    - Either way, go to IDLE.
- FIFO:
  - Write/read pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap-around.
  - Push when full: byte discarded, overrun set, contents unchanged.
  - Pop when empty: no pointer change, no error.
  - Push and pop in the same clk while full: both happen; no overrun.
- Register map (bus accesses qualify on cs):
  - 4'h0 DATA read:
    - d_out = {8'h00, FIFO head}, or 16'h0000 when empty.
    - The pop takes effect on the clk edge where cs&rd&addr==0.
  - 4'h2 STATUS read: d_out = {12'h000, overrun, frame_err, full, ~empty}.
  - 4'h2 STATUS write: d_in[3] = 1 clears overrun; d_in[2] = 1 clears frame_err.
    - If a set event and a clear land in the same cycle, the set wins.
  - Other offsets: read 16'h0000; writes are ignored.
- d_out is combinational from the current registers when cs=1, and 16'h0000 when cs=0.
- rx_avail = ~empty, registered via the FIFO state.

Test Plan:
- Bench uses CLK_FREQ=1600000, BAUD=100000 (DIV=1, 16 clk/bit).
- Single byte: drive 0x55 frame (start, 1010_1010 LSB first, stop).
  - About 152 clk after the start edge, rx_avail=1 and STATUS=16'h0001.
  - Read 4'h0 → 16'h0055; next STATUS=16'h0000.
- Glitch: pull the line low for 4 clk, then high.
  - FSM returns to IDLE; no push; STATUS=16'h0000.
- Frame error: send 0xA3 with stop bit=0.
  - STATUS=16'h0004, FIFO empty.
  - Write 0x0004 to 4'h2 → STATUS=16'h0000.
- Overrun: send 0x01..0x05 back-to-back with no reads.
  - STATUS=16'h000B.
  - Reads return 0x01, 0x02, 0x03, 0x04, then 16'h0000.
- Full boundary: with the FIFO full, read DATA in the same cycle that the 5th byte is pushed.
  - No overrun; the following reads return bytes 2..5.
- Reset mid-frame: assert rst during DATA bit 4.
  - d_out=0 and rx_avail=0 asynchronously.
  - A clean 0x7E frame after release is received correctly.
